// File: rtl/mul_seq_shift_add.sv
// Sequential shift-add multiplier, unsigned or two's-complement per operation; one product bit per RUN cycle.
// Product valid WIDTH cycles after accept; out_ready low holds DONE and blocks new operands.
module mul_seq_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_sh;

    // -2^(W-1) negates to itself, which reads correctly as the unsigned magnitude 2^(W-1).
    assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;

    assign sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign acc_sh = {sum, acc_lo_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_d    = neg_q;
        p_d      = p_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = mag_a;
                    acc_hi_d = '0;
                    acc_lo_d = mag_b;
                    neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_d = acc_sh[2*WIDTH-1:WIDTH];
                acc_lo_d = acc_sh[WIDTH-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = neg_q ? -acc_sh : acc_sh;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Bench for mul_seq_shift_add: WIDTH=16 and WIDTH=8 instances against a transaction-level model.
module tb_mul_seq_shift_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic [1:0]  sgn_v;
    logic [15:0] a_v [2];
    logic [15:0] b_v [2];
    logic [1:0]  in_rdy;
    logic [1:0]  out_vld;
    logic [1:0]  bsy;
    logic [31:0] p16;
    logic [15:0] p8;
    logic [31:0] p_arr [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mul_seq_shift_add #(.WIDTH(16)) u_w16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_rdy[0]),
        .a         (a_v[0]),
        .b         (b_v[0]),
        .sgn       (sgn_v[0]),
        .out_valid (out_vld[0]),
        .out_ready (out_ready[0]),
        .p         (p16),
        .busy      (bsy[0])
    );

    mul_seq_shift_add #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_rdy[1]),
        .a         (a_v[1][7:0]),
        .b         (b_v[1][7:0]),
        .sgn       (sgn_v[1]),
        .out_valid (out_vld[1]),
        .out_ready (out_ready[1]),
        .p         (p8),
        .busy      (bsy[1])
    );

    assign p_arr[0] = p16;
    assign p_arr[1] = {16'h0000, p8};

    function automatic int wid(int i);
        return (i == 0) ? 16 : 8;
    endfunction

    // Exact integer product of the operands as interpreted in w-bit unsigned or signed form.
    function automatic logic [31:0] prod(int w, logic [15:0] x, logic [15:0] y, logic s);
        longint xv, yv, r;
        logic [31:0] mask;
        xv = longint'(x) & ((longint'(1) << w) - 1);
        yv = longint'(y) & ((longint'(1) << w) - 1);
        if (s && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
        if (s && yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
        r    = xv * yv;
        mask = (w == 16) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        return r[31:0] & mask;
    endfunction

    // Transaction model: accept in IDLE, product appears WIDTH edges later, leaves on out_ready.
    logic        m_busy [2];
    logic        m_ov   [2];
    int          m_acc  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_p    [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0;
                m_ov[i]   <= 1'b0;
                m_p[i]    <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_ov[i]) begin
                    if (out_ready[i]) begin
                        m_ov[i]   <= 1'b0;
                        m_busy[i] <= 1'b0;
                    end
                end else if (m_busy[i]) begin
                    if (cyc == m_acc[i] + wid(i)) begin
                        m_ov[i] <= 1'b1;
                        m_p[i]  <= m_pend[i];
                    end
                end else if (in_valid[i]) begin
                    m_busy[i] <= 1'b1;
                    m_acc[i]  <= cyc;
                    m_pend[i] <= prod(wid(i), a_v[i], b_v[i], sgn_v[i]);
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i),      32'(bsy[i]),     32'(m_busy[i]));
                chk($sformatf("in_ready[%0d]", i),  32'(in_rdy[i]),  32'(!m_busy[i]));
                chk($sformatf("out_valid[%0d]", i), 32'(out_vld[i]), 32'(m_ov[i]));
                chk($sformatf("p[%0d]", i),         p_arr[i],        m_p[i]);
            end
        end
    end

    task automatic op(int i, logic [15:0] x, logic [15:0] y, logic s);
        int g = 0;
        @(negedge clk);
        while (!in_rdy[i] && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL op_wait[%0d]: in_ready low for %0d cycles, required high", i, g);
        end
        a_v[i] = x; b_v[i] = y; sgn_v[i] = s; in_valid[i] = 1'b1;
        @(negedge clk);
        in_valid[i] = 1'b0;
        a_v[i] = 16'($urandom); b_v[i] = 16'($urandom); sgn_v[i] = 1'($urandom);
    endtask

    // Called at the negedge right after the accepting edge; lat counts edges until out_valid.
    task automatic wait_done(int i, output int lat);
        lat = 0;
        while (!out_vld[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_vld[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_wait[%0d]: out_valid low after %0d cycles, required high", i, lat);
        end
    endtask

    task automatic dir(int i, logic [15:0] x, logic [15:0] y, logic s, logic [31:0] exp, string nm);
        int lat;
        op(i, x, y, s);
        wait_done(i, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(wid(i)));
        chk(nm, p_arr[i], exp);
    endtask

    function automatic logic [15:0] pick(int w);
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'h0001 << (w - 1);
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_random(int i, int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(i, pick(wid(i)), pick(wid(i)), 1'($urandom));
        end
    endtask

    initial begin
        int lat;
        logic [1:0] rdone;
        rst_n = 1'b0; in_valid = 2'b00; out_ready = 2'b11; sgn_v = 2'b00;
        a_v[0] = '0; a_v[1] = '0; b_v[0] = '0; b_v[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_p16", p16, 32'h0);
        chk("rst_out_valid", 32'(out_vld[0]), 32'h0);
        chk("rst_in_ready", 32'(in_rdy[0]), 32'h1);
        rst_n = 1'b1;

        dir(0, 16'd50,   16'd50,   1'b0, 32'h0000_09C4, "u50x50");
        dir(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "uFFFFxFFFF");
        dir(0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, "s-1x-1");
        dir(0, 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, "s-3x5");
        dir(0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "s8000x8000");
        dir(0, 16'h0000, 16'h1234, 1'b0, 32'h0000_0000, "u0x1234");
        dir(1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, "w8_uFFxFF");
        dir(1, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000, "w8_s80x80");

        // Backpressure: hold DONE for 10 cycles while in_valid is asserted.
        out_ready[0] = 1'b0;
        dir(0, 16'h1234, 16'h5678, 1'b0, 32'h0626_0060, "u1234x5678");
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'b1; a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_vld[0]), 32'h1);
            chk("hold_in_ready", 32'(in_rdy[0]), 32'h0);
            chk("hold_p", p16, 32'h0626_0060);
        end
        a_v[0] = 16'd3; b_v[0] = 16'd7; sgn_v[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 32'(out_vld[0]), 32'h0);
        chk("release_in_ready", 32'(in_rdy[0]), 32'h1);
        @(negedge clk);
        chk("b2b_busy", 32'(bsy[0]), 32'h1);
        in_valid[0] = 1'b0; a_v[0] = 16'hDEAD; b_v[0] = 16'hBEEF; sgn_v[0] = 1'b1;
        wait_done(0, lat);
        chk("b2b_lat", 32'(lat), 32'd16);
        chk("b2b_p", p16, 32'd21);

        // Reset in the middle of RUN.
        op(0, 16'd100, 16'd200, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_p", p16, 32'h0);
        chk("midrst_out_valid", 32'(out_vld[0]), 32'h0);
        chk("midrst_in_ready", 32'(in_rdy[0]), 32'h1);
        chk("midrst_busy", 32'(bsy[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dir(0, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, "post_rst_s7FFFx8000");

        rdone = 2'b00;
        fork
            begin run_random(0, 150);  rdone[0] = 1'b1; end
            begin run_random(1, 1000); rdone[1] = 1'b1; end
            begin
                while (rdone != 2'b11) begin
                    @(negedge clk);
                    out_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
                end
            end
        join
        out_ready = 2'b11;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
